bin_to_bcd_seq: RTL

- Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm, one bit per clock.
- Sits upstream of the per-digit seven-segment decoders and drives their 4-bit digit inputs.
- Digit code 4'hF is used as "blank": the decoders map any code above 9 to all segments off.
- Provides start/busy/done handshake, leading-zero blanking and overflow indication.

---
 rtl/bin_to_bcd_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Drives the 4-bit digit inputs of downstream seven-segment decoders;
// digit code 4'hF is the blank code (decoders show nothing above 9).
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH     = 14,
  parameter int DIGITS        = 4,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // Reset display: a lone "0" in digit 0, upper digits blank when blanking is on.
  function automatic logic [BW-1:0] rst_bcd();
    logic [BW-1:0] r;
    r = (BLANK_LEADING != 0) ? '1 : '0;
    r[3:0] = 4'h0;
    return r;
  endfunction

  localparam logic [63:0]   LIMIT   = pow10(DIGITS);
  localparam logic [BW-1:0] RST_BCD = rst_bcd();

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0]   bin_q, bin_d;
  logic [BW-1:0]          scr_q, scr_d;
  logic                   ovf_flag_q, ovf_flag_d;
  logic [BW-1:0]          bcd_q, bcd_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;
  logic [BW-1:0]          adj;
  logic [BW-1:0]          fmt;

  // Per-digit add-3 correction; digits are independent, carries only move via the shift.
  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    assign adj[4*k +: 4] = (scr_q[4*k +: 4] >= 4'd5) ? scr_q[4*k +: 4] + 4'd3
                                                      : scr_q[4*k +: 4];
  end

  // Leading-zero blanking: scan from the top digit down until the first nonzero digit.
  always_comb begin
    logic lead;
    lead = 1'b1;
    fmt  = scr_q;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if ((BLANK_LEADING != 0) && lead && (scr_q[4*k +: 4] == 4'h0)) fmt[4*k +: 4] = 4'hF;
      else lead = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      scr_q      <= '0;
      ovf_flag_q <= 1'b0;
      bcd_q      <= RST_BCD;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      scr_q      <= scr_d;
      ovf_flag_q <= ovf_flag_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so it is never queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values per state.
  always_comb begin
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    scr_d      = scr_q;
    ovf_flag_d = ovf_flag_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d      = bin_in;
          scr_d      = '0;
          cnt_d      = CW'(BIN_WIDTH);
          // Scratch drops bits shifted past the top digit, so range is judged up front.
          ovf_flag_d = (64'(bin_in) >= LIMIT);
        end
      end
      SHIFT: begin
        scr_d = {adj[BW-2:0], bin_q[BIN_WIDTH-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CW'(1);
      end
      FINISH: begin
        bcd_d  = ovf_flag_q ? '1 : fmt;
        ovf_d  = ovf_flag_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign bcd_out  = bcd_q;

endmodule
